imm_extend_unit: RTL and testbench

Parametrised, registered immediate-extension unit for the 16-bit datapath. It takes an `IN_W`-bit instruction immediate and produces an `OUT_W`-bit operand by sign-extension, zero-extension or upper-placement. A preceding prefix word can supply the high bits instead. It sits between decode and the operand-select mux, with a valid/ready handshake on each side, and adds a prefix-hold state machine with timeout and overrun reporting.

---
 rtl/imm_pkg.sv | 21 ++
 rtl/imm_format.sv | 41 ++++
 rtl/imm_extend_unit.sv | 103 ++++++++++
 tb/tb_imm_extend_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared types and default widths for the immediate-extension unit.
// Modes, prefix-hold FSM states and default parameter constants.
package imm_pkg;

  typedef enum logic [1:0] {
    SIGN  = 2'b00,
    ZERO  = 2'b01,
    UPPER = 2'b10,
    RSVD  = 2'b11
  } imm_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    PFX_HELD = 1'b1
  } pfx_state_e;

  localparam int IMM_IN_W        = 5;
  localparam int IMM_OUT_W       = 16;
  localparam int IMM_PFX_TIMEOUT = 8;

endpackage

// File: rtl/imm_format.sv
// imm_format: combinational immediate formatter (sign/zero/upper/prefix).
// Ports: imm, mode, use_pfx, pfx in; res out (OUT_W bits).
module imm_format
  import imm_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [1:0]            mode,
  input  logic                  use_pfx,
  input  logic [OUT_W-IN_W-1:0] pfx,
  output logic [OUT_W-1:0]      res
);

  localparam int PFX_W = OUT_W - IN_W;

  imm_mode_e m;
  logic      is_zero;
  logic      is_upper;
  logic      is_sign;

  assign m = imm_mode_e'(mode);

  // A held prefix overrides the mode; reserved mode falls back to sign.
  assign is_zero  = ~use_pfx & (m == ZERO);
  assign is_upper = ~use_pfx & (m == UPPER);
  assign is_sign  = ~use_pfx & ((m == SIGN) | (m == RSVD));

  always_comb begin
    res = '0;
    unique case (1'b1)
      use_pfx:  res = {pfx, imm};
      is_zero:  res = {{PFX_W{1'b0}}, imm};
      is_upper: res = {imm, {PFX_W{1'b0}}};
      is_sign:  res = {{PFX_W{imm[IN_W-1]}}, imm};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate extension with prefix-hold FSM.
// Ports: clk, rst, in_valid/in_ready/imm_in/mode, pfx_valid/pfx_data,
// flush, out_valid/out_ready/out, pfx_overrun (sticky).
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int IN_W        = IMM_IN_W,
  parameter int OUT_W       = IMM_OUT_W,
  parameter int PFX_W       = OUT_W - IN_W,
  parameter int PFX_TIMEOUT = IMM_PFX_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  input  logic             pfx_valid,
  input  logic [PFX_W-1:0] pfx_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             pfx_overrun
);

  localparam int AGE_W = $clog2(PFX_TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(PFX_TIMEOUT - 1);

  pfx_state_e       state;
  logic [PFX_W-1:0] pfx_reg;
  logic [AGE_W-1:0] age;
  logic             in_fire;
  logic [OUT_W-1:0] fmt;

  assign in_ready = ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;

  // Only a prefix captured on an earlier edge applies to this immediate.
  imm_format #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_fmt (
    .imm     (imm_in),
    .mode    (mode),
    .use_pfx (state == PFX_HELD),
    .pfx     (pfx_reg),
    .res     (fmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pfx_reg     <= '0;
      age         <= '0;
      out_valid   <= 1'b0;
      out         <= '0;
      pfx_overrun <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      age       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        out       <= fmt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (pfx_valid) begin
            pfx_reg <= pfx_data;
            age     <= '0;
            state   <= PFX_HELD;
          end
        end
        PFX_HELD: begin
          if (in_fire) begin
            age <= '0;
            if (pfx_valid) begin
              pfx_reg <= pfx_data;
            end else begin
              state <= IDLE;
            end
          end else if (pfx_valid) begin
            pfx_reg     <= pfx_data;
            age         <= '0;
            pfx_overrun <= 1'b1;
          end else if (age == AGE_LAST) begin
            state       <= IDLE;
            age         <= '0;
            pfx_overrun <= 1'b1;
          end else begin
            age <= age + AGE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: scoreboard bench for imm_extend_unit.
// Directed vectors push expected results; a monitor pops on each handshake.
module tb_imm_extend_unit;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  imm_in = '0;
  logic [1:0]  mode = 2'b00;
  logic        pfx_valid = 1'b0;
  logic [10:0] pfx_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
  logic        pfx_overrun;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  imm_extend_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .imm_in      (imm_in),
    .mode        (mode),
    .pfx_valid   (pfx_valid),
    .pfx_data    (pfx_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .pfx_overrun (pfx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", out);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL sb_out: got %h expected %h", out, e);
        end
      end
    end
  end

  task automatic send(input logic [4:0] i, input logic [1:0] m,
                      input logic [15:0] e);
    int n;
    in_valid = 1'b1;
    imm_in   = i;
    mode     = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pfx(input logic [10:0] d);
    pfx_valid = 1'b1;
    pfx_data  = d;
    @(posedge clk);
    #1;
    pfx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out", out, 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_overrun", 16'(pfx_overrun), 16'h0);
    idle(2);
    rst = 1'b0;
    out_ready = 1'b1;

    // Basic modes, back to back.
    send(5'b10110, SIGN,  16'hFFF6);
    send(5'b10110, ZERO,  16'h0016);
    send(5'b10110, UPPER, 16'hB000);
    send(5'b10110, RSVD,  16'hFFF6);
    send(5'b01010, SIGN,  16'h000A);
    idle(2);

    // Prefix applies to next immediate only.
    pfx(11'h2A5);
    send(5'h03, ZERO, 16'h54A3);
    send(5'h03, SIGN, 16'h0003);
    idle(2);

    // Backpressure: stalled result holds, queued immediate waits.
    out_ready = 1'b0;
    send(5'b10110, SIGN, 16'hFFF6);
    in_valid = 1'b1;
    imm_in   = 5'h01;
    mode     = ZERO;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 16'(in_ready), 16'h0);
      chk("stall_valid", 16'(out_valid), 16'h1);
      chk("stall_out", out, 16'hFFF6);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sb.push_back(16'h0001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_out", out, 16'h0001);
    idle(2);
    chk("pre_timeout_overrun", 16'(pfx_overrun), 16'h0);

    // Held prefix times out.
    pfx(11'h123);
    idle(10);
    chk("timeout_overrun", 16'(pfx_overrun), 16'h1);
    send(5'h1F, SIGN, 16'hFFFF);
    idle(2);

    // Reset while a result is pending and a prefix is held.
    out_ready = 1'b0;
    send(5'h09, ZERO, 16'h0009);
    pfx(11'h055);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_out", out, 16'h0);
    chk("mid_rst_in_ready", 16'(in_ready), 16'h1);
    chk("mid_rst_overrun", 16'(pfx_overrun), 16'h0);
    sb.delete();
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    send(5'h04, ZERO, 16'h0004);
    idle(2);

    // Overwrite of a held prefix.
    pfx(11'h100);
    pfx(11'h0AB);
    chk("overwrite_overrun", 16'(pfx_overrun), 16'h1);
    send(5'h02, ZERO, 16'h1562);
    idle(2);

    // Prefix and accept in the same cycle.
    pfx_valid = 1'b1;
    pfx_data  = 11'h001;
    in_valid  = 1'b1;
    imm_in    = 5'h02;
    mode      = ZERO;
    sb.push_back(16'h0002);
    @(posedge clk);
    #1;
    pfx_valid = 1'b0;
    in_valid  = 1'b0;
    send(5'h00, SIGN, 16'h0020);
    idle(2);

    // Flush drops the accept, the output and the held prefix.
    out_ready = 1'b0;
    send(5'h05, ZERO, 16'h0005);
    pfx(11'h3FF);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    imm_in    = 5'h07;
    mode      = ZERO;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 16'(out_valid), 16'h0);
    idle(1);
    send(5'h03, ZERO, 16'h0003);
    idle(3);
    chk("sb_drained", 16'(sb.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
